// File: rtl/data_route_pkg.sv
// Shared constants for the PS-DMA data route: bus widths, packing ratios
// and the beat-counter width helper used by the packers.
`timescale 1ns/1ps
package data_route_pkg;

    localparam int D128  = 128;
    localparam int D1536 = 1536;
    localparam int D6144 = 6144;

    localparam int RATIO_128_1536  = 12;
    localparam int RATIO_1536_6144 = 4;

    // Smallest width w with 2^w > ratio, so the counter can hold 0..ratio-1.
    function automatic int cnt_width(input int ratio);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) <= ratio) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_reg_slice_1536.sv
// Output register stage of an AXI-Stream packer: loads a word on request,
// holds it under backpressure and drops valid after the handshake.
`timescale 1ns/1ps
module axis_reg_slice_1536
    import data_route_pkg::*;
#(
    parameter int W = D1536
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         out_free,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready
);

    assign out_free = ~m_axis_tvalid | m_axis_tready;

    // A load wins over a simultaneous handshake so valid stays high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= load_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= load_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/in128_out1536.sv
// Packs a 128-bit AXI-Stream into 1536-bit words, 12 beats per word,
// zero-padding and flushing early on tlast.
`timescale 1ns/1ps
module in128_out1536
    import data_route_pkg::*;
#(
    parameter int IN_W  = D128,
    parameter int OUT_W = D1536,
    parameter int RATIO = RATIO_128_1536,
    parameter int CNT_W = cnt_width(RATIO_128_1536)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);

    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] acc;
    logic             acc_last;
    logic             pend;

    logic             accept;
    logic             complete;
    logic             out_free;
    logic             load;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] load_data;
    logic             load_last;

    assign s_axis_tready = ~pend;
    assign accept        = s_axis_tvalid & ~pend;
    assign complete      = accept & ((count == CNT_W'(RATIO - 1)) | s_axis_tlast);
    assign load          = (complete | pend) & out_free;
    assign load_data     = pend ? acc : merged;
    assign load_last     = pend ? acc_last : s_axis_tlast;

    always_comb begin
        merged = acc;
        merged[int'(count) * IN_W +: IN_W] = s_axis_tdata;
    end

    // acc is cleared whenever a word leaves it so unwritten slots of a short
    // frame come out as zero padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            acc_last <= 1'b0;
            pend     <= 1'b0;
        end else if (pend) begin
            if (out_free) begin
                pend     <= 1'b0;
                acc      <= '0;
                acc_last <= 1'b0;
            end
        end else if (accept) begin
            if (complete) begin
                count <= '0;
                if (out_free) begin
                    acc <= '0;
                end else begin
                    acc      <= merged;
                    acc_last <= s_axis_tlast;
                    pend     <= 1'b1;
                end
            end else begin
                acc   <= merged;
                count <= count + 1'b1;
            end
        end
    end

    axis_reg_slice_1536 #(
        .W(OUT_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_data    (load_data),
        .load_last    (load_last),
        .out_free     (out_free),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

endmodule

// File: tb/tb_in128_out1536.sv
// Self-checking bench for in128_out1536: directed scenarios plus randomized
// frames scored against a frame-level repacking model.
`timescale 1ns/1ps
module tb_in128_out1536;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [1535:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    int checks = 0;
    int errors = 0;

    logic [1535:0] exp_data_q[$];
    logic          exp_last_q[$];
    logic [1535:0] model_buf;
    int            model_slot;

    logic          stall_prev = 1'b0;
    logic [1535:0] stall_data;
    logic          stall_last;

    in128_out1536 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    function automatic int diff_slot(input logic [1535:0] a, input logic [1535:0] b);
        for (int j = 0; j < 12; j++)
            if (a[j*128 +: 128] !== b[j*128 +: 128]) return j;
        return 0;
    endfunction

    // Frame-level model: beats fill 128-bit slots in order; a word is emitted
    // after 12 slots or at tlast, with untouched slots left zero.
    task automatic model_beat(input logic [127:0] d, input logic last);
        model_buf[model_slot*128 +: 128] = d;
        model_slot++;
        if (model_slot == 12 || last) begin
            exp_data_q.push_back(model_buf);
            exp_last_q.push_back(last);
            model_buf  = '0;
            model_slot = 0;
        end
    endtask

    task automatic model_clear();
        model_buf  = '0;
        model_slot = 0;
    endtask

    // Output monitor: every handshake is scored against the model, and a
    // stalled word must not change.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_axis_tvalid) begin
                checks++;
                if (m_axis_tdata !== stall_data || m_axis_tlast !== stall_last) begin
                    errors++;
                    $display("[TB] FAIL stall_stable slot %0d got %h/%b exp %h/%b",
                             diff_slot(m_axis_tdata, stall_data),
                             m_axis_tdata[diff_slot(m_axis_tdata, stall_data)*128 +: 128], m_axis_tlast,
                             stall_data[diff_slot(m_axis_tdata, stall_data)*128 +: 128], stall_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_word got slot0 %h exp no word", m_axis_tdata[127:0]);
                end else begin
                    logic [1535:0] ed;
                    logic          el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (m_axis_tdata !== ed || m_axis_tlast !== el) begin
                        errors++;
                        $display("[TB] FAIL word_data slot %0d got %h last %b exp %h last %b",
                                 diff_slot(m_axis_tdata, ed), m_axis_tdata[diff_slot(m_axis_tdata, ed)*128 +: 128],
                                 m_axis_tlast, ed[diff_slot(m_axis_tdata, ed)*128 +: 128], el);
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
        end
    end

    task automatic put_beat(input logic [127:0] d, input logic last, input logic use_model);
        int n;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!s_axis_tready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_axis_tready) begin
            errors++;
            $display("[TB] FAIL input_timeout got tready %b exp 1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (use_model) model_beat(d, last);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_data_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d words pending exp 0", exp_data_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b1 || m_axis_tdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got valid %b last %b ready %b exp 0 0 1",
                     m_axis_tvalid, m_axis_tlast, s_axis_tready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        logic [1535:0] w0;
        logic [7:0]    b;
        m_axis_tready = 1'b1;
        w0 = '0;
        for (int j = 0; j < 12; j++) begin
            b = 8'(j);
            w0[j*128 +: 128] = {16{b}};
        end
        for (int k = 0; k < 24; k++) begin
            b = 8'(k);
            put_beat({16{b}}, k == 23, 1'b1);
            checks++;
            if (s_axis_tready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cont_tready beat %0d got %b exp 1", k, s_axis_tready);
            end
            if (k == 10) begin
                checks++;
                if (m_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cont_early_valid got %b exp 0", m_axis_tvalid);
                end
            end
            if (k == 11) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tdata !== w0) begin
                    errors++;
                    $display("[TB] FAIL cont_word0 got valid %b last %b slot %0d %h exp 1 0 %h",
                             m_axis_tvalid, m_axis_tlast, diff_slot(m_axis_tdata, w0),
                             m_axis_tdata[diff_slot(m_axis_tdata, w0)*128 +: 128],
                             w0[diff_slot(m_axis_tdata, w0)*128 +: 128]);
                end
            end
            if (k == 23) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL cont_word1 got valid %b last %b exp 1 1", m_axis_tvalid, m_axis_tlast);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cont_valid_drop got %b exp 0", m_axis_tvalid);
        end
        wait_drain();
    endtask

    task automatic test_short_frame();
        logic [1535:0] w;
        logic [7:0]    b;
        m_axis_tready = 1'b1;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            b = 8'hA0 + 8'(i);
            w[i*128 +: 128] = {16{b}};
            put_beat({16{b}}, i == 4, 1'b1);
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== w) begin
            errors++;
            $display("[TB] FAIL short_frame got valid %b last %b slot %0d %h exp 1 1 %h",
                     m_axis_tvalid, m_axis_tlast, diff_slot(m_axis_tdata, w),
                     m_axis_tdata[diff_slot(m_axis_tdata, w)*128 +: 128],
                     w[diff_slot(m_axis_tdata, w)*128 +: 128]);
        end
        wait_drain();
    endtask

    task automatic test_single_beat();
        logic [1535:0] w;
        m_axis_tready = 1'b1;
        w = '0;
        w[127:0] = {16{8'h55}};
        put_beat({16{8'h55}}, 1'b1, 1'b1);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== w) begin
            errors++;
            $display("[TB] FAIL single_beat got valid %b last %b slot %0d %h exp 1 1 %h",
                     m_axis_tvalid, m_axis_tlast, diff_slot(m_axis_tdata, w),
                     m_axis_tdata[diff_slot(m_axis_tdata, w)*128 +: 128],
                     w[diff_slot(m_axis_tdata, w)*128 +: 128]);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 24; k++) begin
            b = 8'h30 + 8'(k);
            put_beat({16{b}}, k == 23, 1'b1);
        end
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 ||
            m_axis_tdata[127:0] !== {16{8'h30}}) begin
            errors++;
            $display("[TB] FAIL bp_pend got ready %b valid %b last %b slot0 %h exp 0 1 0 %h",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata[127:0], {16{8'h30}});
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold_ready got %b exp 0", s_axis_tready);
        end
        m_axis_tready = 1'b1;
        wait_drain();
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release got ready %b valid %b exp 1 0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_random();
        logic done;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    int len;
                    len = $urandom_range(1, 40);
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) begin
                                @(posedge clk);
                                #1;
                            end
                        end
                        put_beat({$urandom, $urandom, $urandom, $urandom}, i == len - 1, 1'b1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid_word();
        logic [1535:0] w;
        logic [7:0]    b;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b = 8'hE0 + 8'(i);
            put_beat({16{b}}, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid %b ready %b exp 0 1", m_axis_tvalid, s_axis_tready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        w = '0;
        for (int i = 0; i < 12; i++) begin
            b = 8'h10 + 8'(i);
            w[i*128 +: 128] = {16{b}};
            put_beat({16{b}}, 1'b0, 1'b1);
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tdata !== w) begin
            errors++;
            $display("[TB] FAIL post_reset_word got valid %b last %b slot %0d %h exp 1 0 %h",
                     m_axis_tvalid, m_axis_tlast, diff_slot(m_axis_tdata, w),
                     m_axis_tdata[diff_slot(m_axis_tdata, w)*128 +: 128],
                     w[diff_slot(m_axis_tdata, w)*128 +: 128]);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_short_frame();
        test_single_beat();
        test_backpressure();
        test_random();
        test_reset_mid_word();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
